led_step_ctrl: RTL

- Upstream control stage for the 8-LED running-light shifter.
- Turns three active-low push-buttons into run/pause, direction and speed settings.
- Emits a one-cycle `step` strobe at the selected rate, plus a `dir` level.
- The shifter advances one position per `step`, in the direction given by `dir`. It no longer keeps its own divider.

---
 rtl/led_step_ctrl_pkg.sv | 25 ++
 rtl/led_step_ctrl_if.sv | 29 ++
 rtl/led_step_ctrl_key_debounce.sv | 50 +++++
 rtl/led_step_ctrl.sv | 70 +++++++
 4 files changed

// File: rtl/led_step_ctrl_pkg.sv
// rtl/led_step_ctrl_pkg.sv - shared constants and helpers for the LED step controller
package led_ctrl_pkg;

  // Key positions within key_n
  localparam int KEY_RUN = 0;
  localparam int KEY_DIR = 1;
  localparam int KEY_SPD = 2;

  // Direction encoding seen by the LED shifter
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Speed setting: SPEED_CNT rates selected by a SPEED_W-bit index
  localparam int SPEED_W   = 2;
  localparam int SPEED_CNT = 4;

  // Cycle to the next speed, wrapping from the slowest-divided rate back to 0
  function automatic logic [SPEED_W-1:0] next_speed(input logic [SPEED_W-1:0] s);
    if (s == SPEED_W'(SPEED_CNT - 1)) begin
      return '0;
    end
    return s + 1'b1;
  endfunction

endpackage

// File: rtl/led_step_ctrl_if.sv
// rtl/led_step_ctrl_if.sv - button inputs and step/dir/status outputs of the controller
interface led_step_ctrl_if;
  import led_ctrl_pkg::*;

  logic [2:0]         key_n;
  logic               step;
  logic               dir;
  logic               running;
  logic [SPEED_W-1:0] speed_idx;

  // Controller side: samples the buttons, drives the shifter controls
  modport master (
    input  key_n,
    output step,
    output dir,
    output running,
    output speed_idx
  );

  // Board/shifter side: drives the buttons, consumes the controls
  modport slave (
    output key_n,
    input  step,
    input  dir,
    input  running,
    input  speed_idx
  );

endinterface

// File: rtl/led_step_ctrl_key_debounce.sv
// rtl/led_step_ctrl_key_debounce.sv - two-flop synchronizer plus counting debouncer for one button
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_raw,
  output logic key_level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into clk domain before anything looks at it
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // a released-to-pressed flip raises press for exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      key_level <= 1'b1;
      press     <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == key_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt       <= '0;
        key_level <= sync2;
        press     <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_step_ctrl.sv
// rtl/led_step_ctrl.sv - button-driven run/direction/speed control and step-rate divider
module led_step_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int BASE_DIV        = 1200000
) (
  input  logic            clk,
  input  logic            rst,
  led_step_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(BASE_DIV);

  logic [2:0]       press;
  logic [2:0]       key_level_unused;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;
  logic             at_end;
  logic             spd_ev;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk      (clk),
      .rst      (rst),
      .key_n_raw(bus.key_n[k]),
      .key_level(key_level_unused[k]),
      .press    (press[k])
    );
  end

  // Terminal count of the divider for the current speed: BASE_DIV, /2, /4, /8
  always_comb begin
    div_m1 = CNT_W'((BASE_DIV >> bus.speed_idx) - 1);
    at_end = (cnt == div_m1);
    spd_ev = press[KEY_SPD];
  end

  // Settings registers and divider; a speed change restarts the count and
  // swallows a step that would have fired in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      bus.step      <= 1'b0;
      bus.dir       <= DIR_LEFT;
      bus.running   <= 1'b1;
      bus.speed_idx <= '0;
    end else begin
      bus.step <= bus.running & at_end & ~spd_ev;

      if (spd_ev) begin
        cnt           <= '0;
        bus.speed_idx <= next_speed(bus.speed_idx);
      end else if (bus.running) begin
        cnt <= at_end ? '0 : cnt + 1'b1;
      end

      if (press[KEY_RUN]) begin
        bus.running <= ~bus.running;
      end

      if (press[KEY_DIR]) begin
        bus.dir <= (bus.dir == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
      end
    end
  end

endmodule
